truth_table_scanner: RTL

Sequential stimulus-and-capture stage that sits directly upstream of a 3-input combinational truth-table gate (`in1`, `in2`, `in3` → `out`). On `start` it walks all eight input combinations in ascending order, waits a programmable settle time per row, samples the gate's output, and assembles an 8-bit truth-table signature in the team's hex-name convention. It compares the signature against a parameterised expected value, so a gate such as `0x89` is checked in-circuit by a single scan.

---
 rtl/truth_table_scanner.sv | 139 +++++++++++++
 1 files changed

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: drives all eight rows of a 3-input gate in ascending
// order, waits SETTLE cycles per row, samples the gate output and assembles
// an 8-bit signature (bit 7 = row 000, bit 0 = row 111), then compares it
// against EXPECTED.
// Optional feature macro: SCAN_STABILITY_CHECK_EN (per-row settle check that
// flags rows whose output moved during the last settle cycle).
module truth_table_scanner #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [7:0]  EXPECTED = 8'h89
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match,
  output logic [7:0] unstable
);

  localparam int unsigned    CW       = (SETTLE == 0) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0]  SETTLE_C = CW'(SETTLE);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    table_q, table_d;
  logic          match_q, match_d;
  logic [2:0]    bit_sel;

`ifdef SCAN_STABILITY_CHECK_EN
  logic [7:0]    unst_q, unst_d;
  logic          early_q, early_d;
`endif

  // Row index maps to signature bit 7-idx so row 000 lands in the MSB.
  assign bit_sel = 3'd7 - idx_q;

  // Next-state logic: row walk, settle countdown, sample capture and final compare.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    match_d = match_q;
`ifdef SCAN_STABILITY_CHECK_EN
    unst_d  = unst_q;
    early_d = early_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          idx_d   = '0;
          cnt_d   = SETTLE_C;
          table_d = '0;
          match_d = 1'b0;
`ifdef SCAN_STABILITY_CHECK_EN
          unst_d  = '0;
`endif
        end
      end
      S_SCAN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
`ifdef SCAN_STABILITY_CHECK_EN
          if (cnt_q == CNT_ONE) early_d = dut_out;
`endif
        end else begin
          table_d[bit_sel] = dut_out;
`ifdef SCAN_STABILITY_CHECK_EN
          if ((SETTLE != 0) && (early_q != dut_out)) unst_d[bit_sel] = 1'b1;
`endif
          if (idx_q == 3'd7) begin
            state_d = S_DONE;
            // Compare against the signature including this last sample so
            // match is already valid in the DONE cycle.
`ifdef SCAN_STABILITY_CHECK_EN
            match_d = (table_d == EXPECTED) && (unst_d == '0);
`else
            match_d = (table_d == EXPECTED);
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            cnt_d = SETTLE_C;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      match_q <= 1'b0;
`ifdef SCAN_STABILITY_CHECK_EN
      unst_q  <= '0;
      early_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      match_q <= match_d;
`ifdef SCAN_STABILITY_CHECK_EN
      unst_q  <= unst_d;
      early_q <= early_d;
`endif
    end
  end

  assign busy              = (state_q == S_SCAN);
  assign done              = (state_q == S_DONE);
  assign {in1, in2, in3}   = busy ? idx_q : 3'b000;
  assign table_out         = table_q;
  assign match             = match_q;
`ifdef SCAN_STABILITY_CHECK_EN
  assign unstable          = unst_q;
`else
  assign unstable          = '0;
`endif

endmodule
